tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
- Sequences the PAM transmit framer: decides when a frame starts, what type it is, and which segment is on air each cycle.
- Segments are SYNC (m-sequence), PILOT, PAYLOAD (read from the symbol buffer) and GUARD.
- Arbitrates between two requesters: a full payload buffer (data frame) and a calibration beacon (sync+pilot only, no payload).
- Sits between the PAM mapper/buffer and the DAC-side framer, which muxes samples from seg_sel/seg_cnt.

Parameters:
- SYNC_LEN, 31, sync segment length in cycles (>=1)
- PILOT_LEN, 4, pilot segment length in cycles (>=1)
- PAYLOAD_LEN, 1024, payload segment length in cycles (>=1)
- GUARD_LEN, 8, idle guard after every frame (>=1)
- CNT_W, 11, width of seg_cnt; must hold max(LEN)-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_en  in  1  level; 0 = no new frame may start
- data_req  in  1  level; payload buffer holds PAYLOAD_LEN symbols
- beacon_req  in  1  single-cycle pulse requesting a beacon frame
- seg_sel  out  3  0 IDLE, 1 SYNC, 2 PILOT, 3 PAYLOAD, 4 GUARD
- seg_cnt  out  CNT_W  index within current segment, 0..LEN-1; 0 in IDLE
- pay_rd_en  out  1  buffer read strobe, high every PAYLOAD cycle
- frame_type  out  1  0 data, 1 beacon; held for whole frame
- frame_start  out  1  pulse, first SYNC cycle
- frame_done  out  1  pulse, last GUARD cycle
- beacon_ovf  out  1  sticky; beacon pulse lost while one already pending
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0; state IDLE; beacon pending 0; RR pointer = data-preferred. Reset asserted mid-frame aborts immediately, no frame_done.
- All outputs registered, driven from the state/counter registers.
- beacon_req pulse sets beacon_pend. beacon_pend clears in the cycle the beacon is granted. A pulse arriving while beacon_pend=1 sets beacon_ovf; the request itself is dropped. A pulse arriving in the grant cycle re-sets beacon_pend; the new pulse wins over the clear.
- Grant from IDLE requires tx_en=1 and a request. Requests are sampled at the clock edge ending the IDLE cycle. SYNC starts the next cycle, so latency is 1 cycle.
- Arbitration:
  - Only one of data_req/beacon_pend asserted: grant it.
  - Both asserted: round-robin; grant the type not granted last.
  - RR pointer updates on each grant.
- FSM: IDLE -> SYNC -> PILOT -> {PAYLOAD if data | GUARD if beacon}; PAYLOAD -> GUARD; GUARD -> IDLE.
  - Each segment lasts exactly its LEN cycles.
  - seg_cnt counts 0..LEN-1 and resets to 0 on every segment transition.
  - GUARD always returns to IDLE for at least 1 cycle, even if requests are pending (minimum inter-frame gap = GUARD_LEN+1).
- Frame lengths: data = SYNC_LEN+PILOT_LEN+PAYLOAD_LEN+GUARD_LEN (1067 default); beacon = SYNC_LEN+PILOT_LEN+GUARD_LEN (43 default).
- pay_rd_en = (seg_sel==PAYLOAD): exactly PAYLOAD_LEN strobes per data frame, none per beacon frame.
- frame_type is latched at grant, valid from first SYNC cycle to last GUARD cycle, and holds its value in IDLE.
- frame_done coincides with seg_sel=GUARD, seg_cnt=GUARD_LEN-1. frame_cnt increments on the same edge as frame_done deasserts.
- tx_en deasserting mid-frame does not abort; the frame completes, then the block stays IDLE until tx_en=1.
- data_req may drop during a frame; it is ignored until the next IDLE.
- beacon_ovf clears only on reset.

Test Plan:
- Data only: tx_en=1, data_req=1 from cycle 0.
  - frame_start at cycle 1.
  - seg_sel 1 for 31 cycles, then 2 for 4, 3 for 1024 with 1024 pay_rd_en, then 4 for 8.
  - frame_done at cycle 1067; IDLE at 1068; frame_cnt=1.
- Beacon only: single beacon_req pulse.
  - 31 SYNC, 4 PILOT, 8 GUARD; zero pay_rd_en; frame_type=1; frame_cnt=1.
- Contention: data_req held high, beacon_req pulsed during the first data frame.
  - Frame order is data, beacon, data.
  - Each gap between frames is exactly 1 IDLE cycle.
- Overflow: two beacon pulses during a data frame -> beacon_ovf=1; exactly one beacon frame follows.
- tx_en dropped at PAYLOAD seg_cnt=100 -> the frame completes normally with 1024 reads; no new frame while tx_en=0 even with data_req=1.
- Reset at PAYLOAD seg_cnt=500 -> all outputs 0 asynchronously; no frame_done; frame_cnt=0; after release with data_req=1, a full frame restarts from SYNC.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: sequences SYNC/PILOT/PAYLOAD/GUARD segments and arbitrates data vs beacon frames.
module tx_frame_scheduler #(
  parameter int SYNC_LEN    = 31,
  parameter int PILOT_LEN   = 4,
  parameter int PAYLOAD_LEN = 1024,
  parameter int GUARD_LEN   = 8,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             data_req,
  input  logic             beacon_req,
  output logic [2:0]       seg_sel,
  output logic [CNT_W-1:0] seg_cnt,
  output logic             pay_rd_en,
  output logic             frame_type,
  output logic             frame_start,
  output logic             frame_done,
  output logic             beacon_ovf,
  output logic [15:0]      frame_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, SYNC = 3'd1, PILOT = 3'd2, PAYLOAD = 3'd3, GUARD = 3'd4} seg_t;
  seg_t st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_max;
  logic seg_last, grant, grant_beacon, rr_beacon, beacon_pend;
  always_comb begin
    cnt_max = st == SYNC    ? CNT_W'(SYNC_LEN - 1)    :
              st == PILOT   ? CNT_W'(PILOT_LEN - 1)   :
              st == PAYLOAD ? CNT_W'(PAYLOAD_LEN - 1) : CNT_W'(GUARD_LEN - 1);
    seg_last = (st != IDLE) && (cnt == cnt_max);
    grant = (st == IDLE) && tx_en && (data_req || beacon_pend);
    // on a tie rr_beacon says whether the beacon's turn has come
    grant_beacon = grant && beacon_pend && (!data_req || rr_beacon);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    st_nxt = grant ? SYNC : IDLE;
      SYNC:    st_nxt = seg_last ? PILOT : SYNC;
      PILOT:   st_nxt = seg_last ? (frame_type ? GUARD : PAYLOAD) : PILOT;
      PAYLOAD: st_nxt = seg_last ? GUARD : PAYLOAD;
      GUARD:   st_nxt = seg_last ? IDLE : GUARD;
      default: st_nxt = IDLE;
    endcase
    cnt_nxt = (st == IDLE || seg_last) ? '0 : cnt + 1'b1;
  end
  always_comb begin
    seg_sel     = st;
    seg_cnt     = cnt;
    pay_rd_en   = st == PAYLOAD;
    frame_start = st == SYNC && cnt == '0;
    frame_done  = st == GUARD && seg_last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_type  <= 1'b0;
      rr_beacon   <= 1'b0;
      beacon_pend <= 1'b0;
      beacon_ovf  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (grant) begin
        frame_type <= grant_beacon;
        rr_beacon  <= !grant_beacon;
      end
      beacon_pend <= beacon_req || (beacon_pend && !grant_beacon);
      beacon_ovf  <= beacon_ovf || (beacon_req && beacon_pend && !grant_beacon);
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: directed scenarios plus random traffic against a frame-offset reference model.
module tb_tx_frame_scheduler;
  localparam int S = 31, P = 4, L = 1024, G = 8;
  logic clk = 0, rst_n = 0, tx_en = 0, data_req = 0, beacon_req = 0;
  logic [2:0] seg_sel;
  logic [10:0] seg_cnt;
  logic pay_rd_en, frame_type, frame_start, frame_done, beacon_ovf;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  tx_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .data_req(data_req), .beacon_req(beacon_req),
    .seg_sel(seg_sel), .seg_cnt(seg_cnt), .pay_rd_en(pay_rd_en), .frame_type(frame_type),
    .frame_start(frame_start), .frame_done(frame_done), .beacon_ovf(beacon_ovf), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  // reference model: a frame is a span of offsets 0..flen-1 after grant
  bit m_busy, m_type, m_pend, m_ovf, m_last_b;
  int m_k;
  logic [15:0] m_frames;
  int cyc, hist[5], pay, starts, dones, idle_run;
  bit types[$];
  int gaps[$];
  function automatic int flen(bit t);
    return t ? S + P + G : S + P + L + G;
  endfunction
  function automatic logic [34:0] exp_vec();
    int seg, c;
    seg = 0; c = 0;
    if (m_busy) begin
      if (m_k < S) begin seg = 1; c = m_k; end
      else if (m_k < S + P) begin seg = 2; c = m_k - S; end
      else if (!m_type && m_k < S + P + L) begin seg = 3; c = m_k - S - P; end
      else begin seg = 4; c = m_k - S - P - (m_type ? 0 : L); end
    end
    return {3'(seg), 11'(c), seg == 3, m_type, m_busy && m_k == 0,
            m_busy && m_k == flen(m_type) - 1, m_ovf, m_frames};
  endfunction
  function automatic logic [34:0] act_vec();
    return {seg_sel, seg_cnt, pay_rd_en, frame_type, frame_start, frame_done, beacon_ovf, frame_cnt};
  endfunction
  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_type = 0; m_pend = 0; m_ovf = 0; m_last_b = 1; m_k = 0; m_frames = 0;
  endtask
  task automatic model_step();
    bit g, gt;
    g = !m_busy && tx_en && (data_req || m_pend);
    gt = g && (data_req && m_pend ? !m_last_b : m_pend);
    if (m_busy) begin
      if (m_k == flen(m_type) - 1) begin m_busy = 0; m_frames++; end
      else m_k++;
    end else if (g) begin
      m_busy = 1; m_k = 0; m_type = gt; m_last_b = gt;
    end
    if (beacon_req && m_pend && !gt) m_ovf = 1;
    m_pend = beacon_req || (m_pend && !gt);
  endtask
  task automatic clear_stats();
    cyc = 0; pay = 0; starts = 0; dones = 0; idle_run = 0;
    foreach (hist[i]) hist[i] = 0;
    types.delete(); gaps.delete();
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("cycle_model", act_vec(), exp_vec());
    if (seg_sel < 5) hist[seg_sel]++;
    if (pay_rd_en) pay++;
    if (frame_start) begin
      if (dones > 0) gaps.push_back(idle_run);
      starts++;
      types.push_back(frame_type);
    end
    if (frame_done) dones++;
    idle_run = seg_sel == 0 ? idle_run + 1 : 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_outputs", act_vec(), 0);
    @(posedge clk); #1;
    rst_n = 1;
    clear_stats();
  endtask
  task automatic pulse_beacon();
    beacon_req = 1; tick(); beacon_req = 0;
  endtask
  initial begin
    int nb;
    // data only
    tx_en = 1; data_req = 1;
    do_reset();
    tick();
    chk("data_start_c1", {frame_start, seg_sel}, {1'b1, 3'd1});
    data_req = 0;
    while (cyc < 1067) tick();
    chk("data_done_c1067", {frame_done, seg_sel, seg_cnt}, {1'b1, 3'd4, 11'd7});
    tick();
    chk("data_idle_c1068", {seg_sel, frame_cnt}, {3'd0, 16'd1});
    chk("data_hist", {hist[1], hist[2], hist[3], hist[4]}, {32'd31, 32'd4, 32'd1024, 32'd8});
    chk("data_reads", pay, 1024);
    // beacon only
    do_reset();
    pulse_beacon();
    repeat (60) tick();
    chk("bcn_hist", {hist[1], hist[2], hist[3], hist[4]}, {32'd31, 32'd4, 32'd0, 32'd8});
    chk("bcn_reads", pay, 0);
    chk("bcn_type", {types.size() == 1, frame_type}, 2'b11);
    chk("bcn_frames", frame_cnt, 1);
    // contention: data, beacon, data with single idle gaps
    do_reset();
    data_req = 1;
    repeat (100) tick();
    pulse_beacon();
    for (int i = 0; i < 3000 && starts < 3; i++) tick();
    chk("cont_bound", starts >= 3, 1);
    chk("cont_order", {types[0], types[1], types[2]}, 3'b010);
    chk("cont_gaps", {gaps[0], gaps[1]}, {32'd1, 32'd1});
    // overflow
    do_reset();
    data_req = 1;
    tick(); tick();
    data_req = 0;
    repeat (50) tick();
    pulse_beacon();
    repeat (10) tick();
    chk("ovf_clear_one", beacon_ovf, 0);
    pulse_beacon();
    chk("ovf_set", beacon_ovf, 1);
    repeat (1300) tick();
    nb = 0;
    foreach (types[i]) nb += types[i];
    chk("ovf_beacons", {nb, starts}, {32'd1, 32'd2});
    chk("ovf_sticky", {beacon_ovf, frame_cnt}, {1'b1, 16'd2});
    // tx_en dropped mid-payload
    do_reset();
    data_req = 1;
    for (int i = 0; i < 2000 && !(seg_sel == 3 && seg_cnt == 100); i++) tick();
    chk("txen_reach", {seg_sel, seg_cnt}, {3'd3, 11'd100});
    tx_en = 0;
    repeat (1500) tick();
    chk("txen_reads", pay, 1024);
    chk("txen_frames", {starts, 16'(frame_cnt), 3'(seg_sel)}, {32'd1, 16'd1, 3'd0});
    tx_en = 1;
    // reset mid-payload
    do_reset();
    for (int i = 0; i < 2000 && !(seg_sel == 3 && seg_cnt == 500); i++) tick();
    chk("rst_reach", {seg_sel, seg_cnt}, {3'd3, 11'd500});
    rst_n = 0;
    #1;
    chk("rst_async", act_vec(), 0);
    chk("rst_no_done", dones, 0);
    do_reset();
    tick();
    chk("rst_restart", {frame_start, seg_sel, frame_cnt}, {1'b1, 3'd1, 16'd0});
    while (cyc < 1068) tick();
    chk("rst_full", {pay, 16'(frame_cnt)}, {32'd1024, 16'd1});
    // random traffic
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      tick();
      if ($urandom_range(199) == 0) tx_en = ~tx_en;
      if ($urandom_range(99) == 0) data_req = ~data_req;
      beacon_req = $urandom_range(149) == 0;
    end
    beacon_req = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
